// File: rtl/mul_sequencer.sv
// mul_sequencer: drives one 2-cycle pipelined 32x32 multiplier to execute MUL/MLA
// directly and 64-bit long multiplies as four 16x16 partial products.
`default_nettype none

module mul_sequencer #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_acc_lo,
  input  logic [31:0] req_acc_hi,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_lo,
  output logic [31:0] resp_hi,
  output logic        resp_n,
  output logic        resp_z,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_CORRECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // cnt holds the current cycle number of the operation (1 = first issue cycle)
  localparam logic [3:0] FIRST_CAP = 4'(1 + MUL_LAT);
  localparam logic [3:0] LAST_ISSUE_LONG = 4'd4;
  localparam logic [3:0] LAST_CAP_LONG = 4'(4 + MUL_LAT);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [63:0] acc;

  logic        is_long, is_signed, accept, capture;
  logic [1:0]  issue_idx, cap_idx;
  logic [63:0] addend, acc_nxt;
  logic [31:0] corr;

  assign is_long   = op[2];
  assign is_signed = op[2] & op[1];
  assign accept    = req_valid && req_ready;
  assign issue_idx = 2'(cnt - 4'd1);
  assign cap_idx   = 2'(cnt - FIRST_CAP);
  // Captures are keyed only to the cycle count, so stale products are ignored
  assign capture   = (state == S_ISSUE || state == S_DRAIN) && (cnt >= FIRST_CAP);
  assign corr      = (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);

  always_comb begin
    addend = {32'd0, mul_result};
    if (is_long) begin
      case (cap_idx)
        2'd0:    addend = {32'd0, mul_result};
        2'd1,
        2'd2:    addend = {16'd0, mul_result, 16'd0};
        default: addend = {mul_result, 32'd0};
      endcase
      acc_nxt = acc + addend;
    end else begin
      acc_nxt = {32'd0, acc[31:0] + mul_result};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      op    <= 3'd0;
      a     <= 32'd0;
      b     <= 32'd0;
      acc   <= 64'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op  <= req_op;
        a   <= req_a;
        b   <= req_b;
        cnt <= 4'd1;
        // Seeding with the accumulator is equivalent mod 2^64 to adding it last
        if (req_op[2])
          acc <= req_op[0] ? {req_acc_hi, req_acc_lo} : 64'd0;
        else
          acc <= (req_op == 3'b001) ? {32'd0, req_acc_lo} : 64'd0;
      end else begin
        if (state == S_ISSUE || state == S_DRAIN)
          cnt <= cnt + 4'd1;
        else if (state == S_DONE && resp_ready)
          cnt <= 4'd0;
        if (capture)
          acc <= acc_nxt;
        else if (state == S_CORRECT)
          acc[63:32] <= acc[63:32] - corr;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_lo    = 32'd0;
    resp_hi    = 32'd0;
    resp_n     = 1'b0;
    resp_z     = 1'b0;
    mul_a      = 32'd0;
    mul_b      = 32'd0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (is_long) begin
          mul_a = issue_idx[1] ? {16'd0, a[31:16]} : {16'd0, a[15:0]};
          mul_b = issue_idx[0] ? {16'd0, b[31:16]} : {16'd0, b[15:0]};
          if (cnt == LAST_ISSUE_LONG) state_nxt = S_DRAIN;
        end else begin
          mul_a     = a;
          mul_b     = b;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (is_long) begin
          if (cnt == LAST_CAP_LONG) state_nxt = is_signed ? S_CORRECT : S_DONE;
        end else if (cnt == FIRST_CAP) begin
          state_nxt = S_DONE;
        end
      end
      S_CORRECT: state_nxt = S_DONE;
      S_DONE: begin
        resp_valid = 1'b1;
        resp_lo    = acc[31:0];
        resp_hi    = is_long ? acc[63:32] : 32'd0;
        resp_n     = is_long ? acc[63] : acc[31];
        resp_z     = is_long ? (acc == 64'd0) : (acc[31:0] == 32'd0);
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer with a 2-cycle multiplier model.
`default_nettype none

module tb_mul_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, req_acc_lo, req_acc_hi;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_lo, resp_hi;
  logic        resp_n, resp_z;
  logic [31:0] mul_a, mul_b;
  logic [31:0] mul_result;
  logic [31:0] pipe1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Behavioural multiplier: low 32 bits of the product, two register stages
  always @(posedge clk) begin
    pipe1      <= mul_a * mul_b;
    mul_result <= pipe1;
  end

  mul_sequencer #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_acc_lo(req_acc_lo), .req_acc_hi(req_acc_hi),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_lo(resp_lo), .resp_hi(resp_hi), .resp_n(resp_n), .resp_z(resp_z),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo, input logic [31:0] hi);
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    req_acc_lo = lo; req_acc_hi = hi;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic [31:0] lo,
                             input logic [31:0] hi, input logic n, input logic z);
    while (cyc < lat - 1) step();
    chk({tag, "_valid_early"}, {63'd0, resp_valid}, 64'd0);
    step();
    chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_hi_lo"}, {resp_hi, resp_lo}, {hi, lo});
    chk({tag, "_nz"}, {62'd0, resp_n, resp_z}, {62'd0, n, z});
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_release"}, {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_op = 3'd0;
    req_a = 32'd0; req_b = 32'd0; req_acc_lo = 32'd0; req_acc_hi = 32'd0;
    step(); step(); step();
    rst = 1'b0;
    chk("reset_ctrl", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
    chk("reset_resp", {resp_hi, resp_lo}, 64'd0);
    chk("reset_flags", {62'd0, resp_n, resp_z}, 64'd0);
    chk("reset_mul", {mul_a, mul_b}, 64'd0);
    step();

    // MUL 7 * -3
    start(3'b000, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0);
    chk("mul_issue", {mul_a, mul_b}, {32'd7, 32'hFFFF_FFFD});
    chk("mul_ready_busy", {63'd0, req_ready}, 64'd0);
    step();
    chk("mul_idle_operands", {mul_a, mul_b}, 64'd0);
    expect_resp("mul", 4, 32'hFFFF_FFEB, 32'd0, 1'b1, 1'b0);
    finish_resp("mul");

    // MLA wraps to 5
    start(3'b001, 32'h0001_0000, 32'h0001_0000, 32'd5, 32'hDEAD_BEEF);
    expect_resp("mla", 4, 32'd5, 32'd0, 1'b0, 1'b0);
    finish_resp("mla");

    // MUL 0*9 gives zero flag
    start(3'b000, 32'd0, 32'd9, 32'd0, 32'd0);
    expect_resp("mul_zero", 4, 32'd0, 32'd0, 1'b0, 1'b1);
    finish_resp("mul_zero");

    // UMULL all-ones: four partial-product issues
    start(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("umull_issue", {mul_a, mul_b}, {32'h0000_FFFF, 32'h0000_FFFF});
      step();
    end
    chk("umull_drain_operands", {mul_a, mul_b}, 64'd0);
    expect_resp("umull", 7, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0);
    finish_resp("umull");

    // SMULL 0x80000000 * 2 = -2^32; check half selection in the issue order
    start(3'b110, 32'h8000_0000, 32'd2, 32'd0, 32'd0);
    chk("smull_p0", {mul_a, mul_b}, {32'h0000_0000, 32'h0000_0002});
    step();
    chk("smull_p1", {mul_a, mul_b}, {32'h0000_0000, 32'h0000_0000});
    step();
    chk("smull_p2", {mul_a, mul_b}, {32'h0000_8000, 32'h0000_0002});
    expect_resp("smull_neg", 8, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    finish_resp("smull_neg");

    // SMULL -1 * -1 = 1
    start(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    expect_resp("smull_m1", 8, 32'd1, 32'd0, 1'b0, 1'b0);
    finish_resp("smull_m1");

    // SMLAL -3 * 5 + 100 = 85
    start(3'b111, 32'hFFFF_FFFD, 32'd5, 32'd100, 32'd0);
    expect_resp("smlal", 8, 32'd85, 32'd0, 1'b0, 1'b0);
    finish_resp("smlal");

    // UMLAL wraps to zero, then hold the response under back-pressure
    start(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_resp("umlal", 7, 32'd0, 32'd0, 1'b0, 1'b1);
    req_valid = 1'b1; req_op = 3'b000; req_a = 32'd5; req_b = 32'd6;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ctrl", {62'd0, resp_valid, req_ready}, {62'd0, 1'b1, 1'b0});
      chk("hold_data", {resp_hi, resp_lo}, 64'd0);
      chk("hold_z", {63'd0, resp_z}, 64'd1);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("hold_release", {62'd0, resp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
    step();
    req_valid = 1'b0;
    cyc = 1;
    chk("b2b_issue", {mul_a, mul_b}, {32'd5, 32'd6});
    chk("b2b_busy", {63'd0, req_ready}, 64'd0);
    expect_resp("b2b_mul", 4, 32'd30, 32'd0, 1'b0, 1'b0);
    finish_resp("b2b_mul");

    // Reset in cycle 3 of a UMULL, then an immediate MUL
    start(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_ctrl", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
    chk("rst_mid_mul", {mul_a, mul_b}, 64'd0);
    start(3'b000, 32'd3, 32'd4, 32'd0, 32'd0);
    expect_resp("post_rst_mul", 4, 32'd12, 32'd0, 1'b0, 1'b0);

    // Reset while a response is pending discards it
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pending", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
    chk("rst_pending_data", {resp_hi, resp_lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
